// File: rtl/rect_fill_arbiter_if.sv
// Pixel-fill job bus between the two drawing requesters, the arbiter and the VGA adapter.
// master = game-logic side (requesters and observers); slave = rect_fill_arbiter.
interface rect_fill_arbiter_if #(
    parameter int unsigned COLOUR_BITS = 3
);
    logic                   req0;
    logic                   req1;
    logic [7:0]             x0_in;
    logic [7:0]             x1_in;
    logic [6:0]             y0_in;
    logic [6:0]             y1_in;
    logic [7:0]             w0_in;
    logic [7:0]             w1_in;
    logic [6:0]             h0_in;
    logic [6:0]             h1_in;
    logic [COLOUR_BITS-1:0] c0_in;
    logic [COLOUR_BITS-1:0] c1_in;
    logic                   ack0;
    logic                   ack1;
    logic                   done0;
    logic                   done1;
    logic [7:0]             vga_x;
    logic [6:0]             vga_y;
    logic [COLOUR_BITS-1:0] vga_colour;
    logic                   vga_plot;
    logic                   busy;
    logic                   grant_id;

    modport master (
        output req0, req1, x0_in, x1_in, y0_in, y1_in, w0_in, w1_in, h0_in, h1_in, c0_in, c1_in,
        input  ack0, ack1, done0, done1, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id
    );

    modport slave (
        input  req0, req1, x0_in, x1_in, y0_in, y1_in, w0_in, w1_in, h0_in, h1_in, c0_in, c1_in,
        output ack0, ack1, done0, done1, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id
    );
endinterface

// File: rtl/rect_fill_arbiter.sv
// Round-robin arbiter that raster-fills one granted rectangle per job into the VGA adapter.
// Define RECT_FILL_ARBITER_CLIP_EN to suppress plotting of off-screen pixels.
module rect_fill_arbiter #(
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter int unsigned COLOUR_BITS = 3
) (
    input logic               CLOCK_50,
    input logic               reset,
    rect_fill_arbiter_if.slave bus
);

`ifdef RECT_FILL_ARBITER_CLIP_EN
    localparam bit ClipEn = 1'b1;
`else
    localparam bit ClipEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             x_q, x_d, w_q, w_d, cx_q, cx_d;
    logic [6:0]             y_q, y_d, h_q, h_d, cy_q, cy_d;
    logic [COLOUR_BITS-1:0] colour_q, colour_d;
    logic                   grant_q, grant_d;
    logic                   last_q, last_d;
    logic                   ack0_q, ack0_d, ack1_q, ack1_d;
    logic                   win;
    logic [8:0]             sum_x;
    logic [7:0]             sum_y;
    logic                   on_screen;
    logic                   drawing;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            colour_q <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            w_q      <= w_d;
            h_q      <= h_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            colour_q <= colour_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        colour_d = colour_q;
        grant_d  = grant_q;
        last_d   = last_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        // On a tie the requester that did not win last time gets the job.
        win      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    x_d      = win ? bus.x1_in : bus.x0_in;
                    y_d      = win ? bus.y1_in : bus.y0_in;
                    w_d      = win ? bus.w1_in : bus.w0_in;
                    h_d      = win ? bus.h1_in : bus.h0_in;
                    colour_d = win ? bus.c1_in : bus.c0_in;
                    cx_d     = '0;
                    cy_d     = '0;
                    grant_d  = win;
                    last_d   = win;
                    ack0_d   = ~win;
                    ack1_d   = win;
                    state_d  = (w_d == 8'd0 || h_d == 7'd0) ? StDone : StDraw;
                end
            end
            StDraw: begin
                if (cx_q == w_q - 8'd1) begin
                    cx_d = '0;
                    if (cy_q == h_q - 7'd1) begin
                        state_d = StDone;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sum_x     = {1'b0, x_q} + {1'b0, cx_q};
        sum_y     = {1'b0, y_q} + {1'b0, cy_q};
        on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
        drawing   = (state_q == StDraw);

        bus.vga_x      = drawing ? sum_x[7:0] : 8'd0;
        bus.vga_y      = drawing ? sum_y[6:0] : 7'd0;
        bus.vga_colour = drawing ? colour_q : '0;
        bus.vga_plot   = drawing && (!ClipEn || on_screen);
        bus.ack0       = ack0_q;
        bus.ack1       = ack1_q;
        bus.done0      = (state_q == StDone) && !grant_q;
        bus.done1      = (state_q == StDone) && grant_q;
        bus.busy       = (state_q != StIdle);
        bus.grant_id   = grant_q;
    end

endmodule
